// File: rtl/uart_slot_pkg.sv
// Shared definitions for the UART slot initiator: slot register map,
// status word bit positions and the engine state encoding.
package uart_slot_pkg;

  localparam logic [4:0] UART_REG_STATUS = 5'd0;
  localparam logic [4:0] UART_REG_DVSR   = 5'd1;
  localparam logic [4:0] UART_REG_TXDATA = 5'd2;
  localparam logic [4:0] UART_REG_RXPOP  = 5'd3;

  localparam int TXFULL_BIT  = 9;
  localparam int RXEMPTY_BIT = 8;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CFG,
    ST_POLL,
    ST_ARB,
    ST_TX_WR,
    ST_RX_POP
  } state_t;

endpackage

// File: rtl/uart_slot_initiator.sv
// Bus initiator for the UART slot: programs the baud divisor, polls the
// status word and moves bytes between the TX/RX streams and the UART FIFOs.
// Optional TX stall timeout with sticky err output: define UART_INIT_TIMEOUT_EN.
module uart_slot_initiator
  import uart_slot_pkg::*;
#(
  parameter int DVSR_W       = 14,
  parameter int DEFAULT_DVSR = 650,
  parameter int TIMEOUT_CYC  = 65535
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              en,
  input  logic [DVSR_W-1:0] cfg_dvsr,
  input  logic              cfg_load,
  input  logic [7:0]        s_tx_data,
  input  logic              s_tx_valid,
  output logic              s_tx_ready,
  output logic [7:0]        m_rx_data,
  output logic              m_rx_valid,
  input  logic              m_rx_ready,
  output logic              cs,
  output logic              read,
  output logic              write,
  output logic [4:0]        addr,
  output logic [31:0]       wr_data,
  input  logic [31:0]       rd_data,
`ifdef UART_INIT_TIMEOUT_EN
  output logic              err,
`endif
  output logic              busy
);

  state_t            state;
  state_t            nxt;
  logic [DVSR_W-1:0] dvsr_reg;
  logic              cfg_pend;
  logic [7:0]        tx_hold;
  logic              tx_hold_v;
  logic              st_txf;
  logic              st_rxe;
  logic [7:0]        st_byte;
  logic              rx_turn;   // 0 gives TX the first tie after reset
  logic              rx_elig;
  logic              tx_elig;
  logic              unused_rd_bits;

`ifdef UART_INIT_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
  logic [CNT_W-1:0] stall_cnt;
`endif

  // Upper status bits carry nothing this engine needs.
  assign unused_rd_bits = ^rd_data[31:10];

  assign s_tx_ready = en & ~tx_hold_v;
  assign busy       = (state != ST_IDLE);
  assign rx_elig    = ~st_rxe & ~m_rx_valid;
  assign tx_elig    = tx_hold_v & ~st_txf;

  // Next-state selection, including the ARB priority and the RX/TX tie-break.
  always_comb begin
    nxt = state;
    case (state)
      ST_IDLE:   if (en) nxt = cfg_pend ? ST_CFG : ST_ARB;
      ST_CFG:    nxt = ST_POLL;
      ST_POLL:   nxt = ST_ARB;
      ST_TX_WR:  nxt = ST_POLL;
      ST_RX_POP: nxt = ST_POLL;
      ST_ARB: begin
        if (!en)                  nxt = ST_IDLE;
        else if (cfg_pend)        nxt = ST_CFG;
        else if (rx_elig && tx_elig) nxt = rx_turn ? ST_RX_POP : ST_TX_WR;
        else if (tx_elig)         nxt = ST_TX_WR;
        else if (rx_elig)         nxt = ST_RX_POP;
        else                      nxt = ST_POLL;
      end
      default:   nxt = ST_IDLE;
    endcase
  end

  // Engine state, registered bus outputs and the stream/status datapath.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= ST_IDLE;
      cs         <= 1'b0;
      read       <= 1'b0;
      write      <= 1'b0;
      addr       <= '0;
      wr_data    <= '0;
      m_rx_data  <= '0;
      m_rx_valid <= 1'b0;
      dvsr_reg   <= DVSR_W'(DEFAULT_DVSR);
      cfg_pend   <= 1'b1;
      tx_hold    <= '0;
      tx_hold_v  <= 1'b0;
      st_txf     <= 1'b1;
      st_rxe     <= 1'b1;
      st_byte    <= '0;
      rx_turn    <= 1'b0;
`ifdef UART_INIT_TIMEOUT_EN
      err        <= 1'b0;
      stall_cnt  <= '0;
`endif
    end else begin
      state <= nxt;

      // Bus cycle for the state being entered; one cycle per access.
      cs      <= 1'b0;
      read    <= 1'b0;
      write   <= 1'b0;
      addr    <= '0;
      wr_data <= '0;
      case (nxt)
        ST_CFG: begin
          cs      <= 1'b1;
          write   <= 1'b1;
          addr    <= UART_REG_DVSR;
          wr_data <= {{(32-DVSR_W){1'b0}}, dvsr_reg};
        end
        ST_POLL: begin
          cs   <= 1'b1;
          read <= 1'b1;
          addr <= UART_REG_STATUS;
        end
        ST_TX_WR: begin
          cs      <= 1'b1;
          write   <= 1'b1;
          addr    <= UART_REG_TXDATA;
          wr_data <= {24'b0, tx_hold};
        end
        ST_RX_POP: begin
          cs    <= 1'b1;
          write <= 1'b1;
          addr  <= UART_REG_RXPOP;
        end
        default: ;
      endcase

      if (m_rx_valid && m_rx_ready) m_rx_valid <= 1'b0;

      if (s_tx_valid && s_tx_ready) begin
        tx_hold   <= s_tx_data;
        tx_hold_v <= 1'b1;
      end

      // Effects of the access that completes at this edge.
      case (state)
        ST_CFG: cfg_pend <= 1'b0;
        ST_POLL: begin
          st_txf  <= rd_data[TXFULL_BIT];
          st_rxe  <= rd_data[RXEMPTY_BIT];
          st_byte <= rd_data[7:0];
        end
        ST_TX_WR: begin
          tx_hold_v <= 1'b0;
          rx_turn   <= 1'b1;
`ifdef UART_INIT_TIMEOUT_EN
          stall_cnt <= '0;
`endif
        end
        ST_RX_POP: begin
          m_rx_data  <= st_byte;
          m_rx_valid <= 1'b1;
          rx_turn    <= 1'b0;
        end
`ifdef UART_INIT_TIMEOUT_EN
        ST_ARB: begin
          if (tx_hold_v && st_txf) begin
            if (stall_cnt == CNT_W'(TIMEOUT_CYC - 1)) begin
              err       <= 1'b1;
              tx_hold_v <= 1'b0;
              stall_cnt <= '0;
            end else begin
              stall_cnt <= stall_cnt + 1'b1;
            end
          end
        end
`endif
        default: ;
      endcase

      // A late reprogram request wins over the clear of an in-flight CFG.
      if (cfg_load) begin
        dvsr_reg <= cfg_dvsr;
        cfg_pend <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_uart_slot_initiator.sv
// Self-checking bench for uart_slot_initiator: expected slot writes and RX
// bytes are queued by the stimulus; a monitor pops and compares them.
module tb_uart_slot_initiator;

  localparam int DVSR_W = 14;
`ifdef UART_INIT_TIMEOUT_EN
  localparam int TB_TIMEOUT = 8;
`else
  localparam int TB_TIMEOUT = 65535;
`endif

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              en = 1'b0;
  logic [DVSR_W-1:0] cfg_dvsr = '0;
  logic              cfg_load = 1'b0;
  logic [7:0]        s_tx_data = '0;
  logic              s_tx_valid = 1'b0;
  logic              s_tx_ready;
  logic [7:0]        m_rx_data;
  logic              m_rx_valid;
  logic              m_rx_ready = 1'b0;
  logic              cs;
  logic              read;
  logic              write;
  logic [4:0]        addr;
  logic [31:0]       wr_data;
  logic [31:0]       rd_data = 32'h300;
  logic              busy;
`ifdef UART_INIT_TIMEOUT_EN
  logic              err;
`endif

  uart_slot_initiator #(
    .DVSR_W      (DVSR_W),
    .DEFAULT_DVSR(650),
    .TIMEOUT_CYC (TB_TIMEOUT)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .en        (en),
    .cfg_dvsr  (cfg_dvsr),
    .cfg_load  (cfg_load),
    .s_tx_data (s_tx_data),
    .s_tx_valid(s_tx_valid),
    .s_tx_ready(s_tx_ready),
    .m_rx_data (m_rx_data),
    .m_rx_valid(m_rx_valid),
    .m_rx_ready(m_rx_ready),
    .cs        (cs),
    .read      (read),
    .write     (write),
    .addr      (addr),
    .wr_data   (wr_data),
    .rd_data   (rd_data),
`ifdef UART_INIT_TIMEOUT_EN
    .err       (err),
`endif
    .busy      (busy)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail = 0;
  int cyc = 0;
  int last_tx_cyc = 0;
  logic [36:0] wr_q[$];   // {addr, data} of each expected slot write
  logic [7:0]  rx_q[$];   // expected RX stream bytes

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push_wr(input logic [4:0] a, input logic [31:0] d);
    wr_q.push_back({a, d});
  endtask

  task automatic wait_drain(input string name, input int budget);
    int k;
    k = 0;
    while (wr_q.size() != 0 && k < budget) begin
      step(1);
      k++;
    end
    check(name, 32'(wr_q.size()), 32'd0);
    wr_q.delete();
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Monitor: every bus access and every RX handshake is checked here.
  initial forever begin
    logic [36:0] e;
    logic [7:0]  b;
    @(negedge clk);
    if (reset && cs) begin
      check("one_strobe", 32'(read ^ write), 32'd1);
      if (read) begin
        check("poll_addr", 32'(addr), 32'd0);
      end else if (wr_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_write: got addr=%0d data=0x%0h, expected no write", addr, wr_data);
      end else begin
        e = wr_q.pop_front();
        check("wr_addr", 32'(addr), 32'(e[36:32]));
        check("wr_data", wr_data, e[31:0]);
        $display("bus write addr=%0d data=0x%0h", addr, wr_data);
        if (addr == 5'd2) last_tx_cyc = cyc;
      end
    end
    if (reset && m_rx_valid && m_rx_ready) begin
      if (rx_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_rx: got 0x%0h, expected no byte", m_rx_data);
      end else begin
        b = rx_q.pop_front();
        check("rx_byte", 32'(m_rx_data), 32'(b));
        $display("rx byte 0x%0h", m_rx_data);
      end
    end
  end

  initial begin
    int hs_cyc;
    int k;
    #2 reset = 1'b0;
    step(2);
    // Reset state
    check("rst_cs", 32'(cs), 32'd0);
    check("rst_read", 32'(read), 32'd0);
    check("rst_write", 32'(write), 32'd0);
    check("rst_addr", 32'(addr), 32'd0);
    check("rst_wr_data", wr_data, 32'd0);
    check("rst_rx_valid", 32'(m_rx_valid), 32'd0);
    check("rst_rx_data", 32'(m_rx_data), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
`ifdef UART_INIT_TIMEOUT_EN
    check("rst_err", 32'(err), 32'd0);
`endif

    // Start-up: divisor write first, then status polling
    push_wr(5'd1, 32'd650);
    reset = 1'b1;
    en = 1'b1;
    wait_drain("startup_cfg", 10);
    step(2);
    check("busy_run", 32'(busy), 32'd1);
    check("tx_ready_idle", 32'(s_tx_ready), 32'd1);

    // TX byte 0x55 with space in the UART FIFO
    rd_data = 32'h100;
    step(4);
    push_wr(5'd2, 32'h55);
    s_tx_data = 8'h55;
    s_tx_valid = 1'b1;
    step(1);
    hs_cyc = cyc;
    s_tx_valid = 1'b0;
    check("tx_ready_held", 32'(s_tx_ready), 32'd0);
    wait_drain("tx_55", 10);
    check("tx_latency_ok", 32'((last_tx_cyc - hs_cyc) <= 3 && last_tx_cyc > hs_cyc), 32'd1);
    step(2);
    check("tx_ready_back", 32'(s_tx_ready), 32'd1);

    // RX byte 0xA5 with consumer stalled: exactly one pop
    rd_data = 32'h0A5;
    m_rx_ready = 1'b0;
    push_wr(5'd3, 32'd0);
    step(20);
    check("rx_valid_held", 32'(m_rx_valid), 32'd1);
    check("rx_data_held", 32'(m_rx_data), 32'hA5);
    check("rx_single_pop", 32'(wr_q.size()), 32'd0);
    wr_q.delete();
    rd_data = 32'h100;
    step(4);
    rx_q.push_back(8'hA5);
    m_rx_ready = 1'b1;
    step(2);
    m_rx_ready = 1'b0;
    check("rx_valid_clr", 32'(m_rx_valid), 32'd0);
    check("rx_q_empty", 32'(rx_q.size()), 32'd0);

    // Alternation after reset: TX goes first
    reset = 1'b0;
    step(2);
    rd_data = 32'h022;
    s_tx_data = 8'h11;
    s_tx_valid = 1'b1;
    m_rx_ready = 1'b1;
    push_wr(5'd1, 32'd650);
    for (int i = 0; i < 3; i++) begin
      push_wr(5'd2, 32'h11);
      push_wr(5'd3, 32'd0);
      rx_q.push_back(8'h22);
    end
    reset = 1'b1;
    wait_drain("alternate", 40);
    rd_data = 32'h300;
    s_tx_valid = 1'b0;
    step(3);
    check("alt_rx_q_empty", 32'(rx_q.size()), 32'd0);

    // Reprogram while a TX byte is stalled on a full FIFO
    step(5);
    push_wr(5'd1, 32'h35);
    cfg_dvsr = 14'h0035;
    cfg_load = 1'b1;
    step(1);
    cfg_load = 1'b0;
    wait_drain("cfg_reload", 10);
    push_wr(5'd2, 32'h11);
    rd_data = 32'h100;
    wait_drain("tx_after_cfg", 10);

    // RX turn then TX; reset lands in the TX write
    rd_data = 32'h044;
    m_rx_ready = 1'b0;
    push_wr(5'd3, 32'd0);
    s_tx_data = 8'h77;
    s_tx_valid = 1'b1;
    step(1);
    s_tx_valid = 1'b0;
    k = 0;
    while (!(cs && write && addr == 5'd2) && k < 20) begin
      step(1);
      k++;
    end
    check("tx77_seen", 32'(cs && write && addr == 5'd2), 32'd1);
    check("tx77_data", wr_data, 32'h77);
    check("pre_rst_rx_valid", 32'(m_rx_valid), 32'd1);
    check("pre_rst_rx_data", 32'(m_rx_data), 32'h44);
    check("rx_before_tx", 32'(wr_q.size()), 32'd0);
    wr_q.delete();
    reset = 1'b0;
    #1;
    check("midrst_cs", 32'(cs), 32'd0);
    check("midrst_write", 32'(write), 32'd0);
    check("midrst_rx_valid", 32'(m_rx_valid), 32'd0);
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_tx_ready", 32'(s_tx_ready), 32'd1);
    step(2);

`ifdef UART_INIT_TIMEOUT_EN
    // TX stall timeout: byte dropped after the stall limit
    rd_data = 32'h300;
    push_wr(5'd1, 32'd650);
    reset = 1'b1;
    s_tx_data = 8'hEE;
    s_tx_valid = 1'b1;
    step(1);
    s_tx_valid = 1'b0;
    k = 0;
    while (!s_tx_ready && k < 100) begin
      step(1);
      k++;
    end
    check("to_tx_ready", 32'(s_tx_ready), 32'd1);
    check("to_err", 32'(err), 32'd1);
    wait_drain("to_no_tx", 4);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
